// File: rtl/lc3b_mem_arbiter_pkg.sv
// ============================================================================
// Module : lc3b_mem_arbiter_pkg
// Brief  : Shared types for the LC-3b instruction/data memory-port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    arb_idle    = 2'd0,
    arb_grant_i = 2'd1,
    arb_grant_d = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    arb_inst = 1'b0,
    arb_data = 1'b1
  } lc3b_arb_port;

  localparam logic [1:0] c_full_word_mask = 2'b11;

endpackage

`default_nettype wire

// File: rtl/lc3b_arb_watchdog.sv
// ============================================================================
// Module : lc3b_arb_watchdog
// Brief  : Saturating wait counter with a sticky timeout flag; 0 disables it.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] c_limit   = CW'(TIMEOUT_CYCLES);
  localparam logic          c_enabled = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_flag;

  // Counter parks at the limit instead of wrapping back to zero.
  always_comb begin
    w_count_next = r_count;
    if (i_clear)
      w_count_next = '0;
    else if (c_enabled && i_enable && (r_count != c_limit))
      w_count_next = r_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_flag  <= r_flag | (c_enabled && (w_count_next == c_limit));
    end
  end

  assign o_timeout = r_flag;

endmodule

`default_nettype wire

// File: rtl/lc3b_mem_arbiter.sv
// ============================================================================
// Module : lc3b_mem_arbiter
// Brief  : Shares one LC-3b memory port between instruction fetch and data
//          accesses. Optional macro ARB_ROUND_ROBIN_EN selects round-robin
//          on contention; otherwise data has fixed priority.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_byte_enable,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic        arb_timeout
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_state_next;
  lc3b_arb_state w_contend_state;
  lc3b_arb_port  r_last_grant;

  logic w_i_req;
  logic w_d_req;
  logic w_granted;

  assign w_i_req   = i_read;
  assign w_d_req   = d_read | d_write;
  assign w_granted = (r_state != arb_idle);

`ifdef ARB_ROUND_ROBIN_EN
  assign w_contend_state = (r_last_grant == arb_inst) ? arb_grant_d : arb_grant_i;
`else
  // Grant history is still tracked so it is observable, but data always wins.
  assign w_contend_state = (r_last_grant == arb_inst) ? arb_grant_d : arb_grant_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= arb_idle;
      r_last_grant <= arb_inst;
    end else begin
      r_state <= w_state_next;
      if ((r_state == arb_idle) && (w_state_next != arb_idle))
        r_last_grant <= (w_state_next == arb_grant_d) ? arb_data : arb_inst;
    end
  end

  // A response or a withdrawn request both end the grant.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      arb_idle: begin
        if (w_i_req && w_d_req) w_state_next = w_contend_state;
        else if (w_d_req)       w_state_next = arb_grant_d;
        else if (w_i_req)       w_state_next = arb_grant_i;
      end
      arb_grant_i: if (mem_resp || !w_i_req) w_state_next = arb_idle;
      arb_grant_d: if (mem_resp || !w_d_req) w_state_next = arb_idle;
      default:     w_state_next = arb_idle;
    endcase
  end

  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = 16'h0000;
    mem_wdata       = 16'h0000;
    unique case (r_state)
      arb_grant_i: begin
        mem_read        = 1'b1;
        mem_byte_enable = c_full_word_mask;
        mem_address     = i_address;
      end
      arb_grant_d: begin
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_byte_enable = d_byte_enable;
        mem_address     = d_address;
        mem_wdata       = d_wdata;
      end
      default: ;
    endcase
  end

  assign i_resp  = (r_state == arb_grant_i) & mem_resp;
  assign d_resp  = (r_state == arb_grant_d) & mem_resp;
  assign i_rdata = w_granted ? mem_rdata : 16'h0000;
  assign d_rdata = w_granted ? mem_rdata : 16'h0000;

  lc3b_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == arb_idle),
    .i_enable (w_granted & ~mem_resp),
    .o_timeout(arb_timeout)
  );

endmodule

`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
// ============================================================================
// Module : tb_lc3b_mem_arbiter
// Brief  : Randomized and directed bench for lc3b_mem_arbiter with a
//          behavioural reference model of the grant/response rules.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3b_mem_arbiter;

  localparam int c_timeout = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read, d_read, d_write, mem_resp;
  logic [15:0] i_address, d_address, d_wdata, mem_rdata;
  logic [1:0]  d_byte_enable;
  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write, arb_timeout;
  logic [1:0]  mem_byte_enable;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.TIMEOUT_CYCLES(c_timeout)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .arb_timeout(arb_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the port (0 none, 1 inst, 2 data), who last won,
  // how long the current owner has waited, and the sticky timeout.
  int m_owner = 0;
  int m_last  = 1;
  int m_wait  = 0;
  bit m_to    = 1'b0;

  int mem_mode   = 0;  // 0 never respond, 1 random, 2 driven by the caller
  bit agent_rand = 1'b0;
  bit i_done = 1'b0, d_done = 1'b0;
  int resp_log[$];

  logic        cap_mem_read, cap_mem_write, cap_i_resp, cap_d_resp, cap_to;
  logic [1:0]  cap_be;
  logic [15:0] cap_addr, cap_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        e_rd, e_wr, e_ir, e_dr, req;
    logic [1:0]  e_be;
    logic [15:0] e_addr, e_wd;
    if (mem_mode == 1)      mem_resp = (m_owner != 0) && ($urandom_range(0, 3) == 0);
    else if (mem_mode == 0) mem_resp = 1'b0;
    mem_rdata = 16'($urandom);
    #4;
    e_rd = 0; e_wr = 0; e_be = 0; e_addr = 0; e_wd = 0;
    if (m_owner == 1) begin
      e_rd = 1; e_be = 2'b11; e_addr = i_address;
    end else if (m_owner == 2) begin
      e_wr = d_write; e_rd = d_read && !d_write;
      e_be = d_byte_enable; e_addr = d_address; e_wd = d_wdata;
    end
    e_ir = (m_owner == 1) && mem_resp;
    e_dr = (m_owner == 2) && mem_resp;
    check("mem_read",  32'(mem_read),        32'(e_rd));
    check("mem_write", 32'(mem_write),       32'(e_wr));
    check("mem_be",    32'(mem_byte_enable), 32'(e_be));
    check("mem_addr",  32'(mem_address),     32'(e_addr));
    check("mem_wdata", 32'(mem_wdata),       32'(e_wd));
    check("i_resp",    32'(i_resp),          32'(e_ir));
    check("d_resp",    32'(d_resp),          32'(e_dr));
    check("timeout",   32'(arb_timeout),     32'(m_to));
    if (e_ir) check("i_rdata", 32'(i_rdata), 32'(mem_rdata));
    if (e_dr) check("d_rdata", 32'(d_rdata), 32'(mem_rdata));
    cap_mem_read = mem_read; cap_mem_write = mem_write; cap_be = mem_byte_enable;
    cap_addr = mem_address; cap_wdata = mem_wdata; cap_to = arb_timeout;
    cap_i_resp = i_resp; cap_d_resp = d_resp;
    if (i_resp) begin i_done = 1'b1; resp_log.push_back(0); end
    if (d_resp) begin d_done = 1'b1; resp_log.push_back(1); end
    if (reset) begin
      m_owner = 0; m_last = 1; m_wait = 0; m_to = 1'b0;
    end else if (m_owner == 0) begin
      m_wait = 0;
      if (i_read && (d_read || d_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner = (m_last == 1) ? 2 : 1;
`else
        m_owner = 2;
`endif
      end else if (d_read || d_write) m_owner = 2;
      else if (i_read)                m_owner = 1;
      if (m_owner != 0) m_last = m_owner;
    end else begin
      req = (m_owner == 1) ? i_read : (d_read || d_write);
      if (!mem_resp && m_wait < c_timeout) m_wait++;
      if (m_wait == c_timeout) m_to = 1'b1;
      if (mem_resp || !req) m_owner = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic agents();
    int kind;
    if (i_done) i_read = 1'b0;
    if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
    i_done = 1'b0; d_done = 1'b0;
    if (agent_rand) begin
      if (i_read && $urandom_range(0, 39) == 0) i_read = 1'b0;
      else if (!i_read && $urandom_range(0, 2) == 0) begin
        i_address = 16'($urandom); i_read = 1'b1;
      end
      if ((d_read || d_write) && $urandom_range(0, 39) == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        d_read = (kind != 1); d_write = (kind != 0);
        d_address = 16'($urandom); d_wdata = 16'($urandom);
        d_byte_enable = 2'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic run_until(input int n);
    for (int k = 0; k < 200 && resp_log.size() < n; k++) begin
      step(); agents();
    end
    check("resp_count", 32'(resp_log.size()), 32'(n));
  endtask

  initial begin
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = 0; d_address = 0; d_wdata = 0; d_byte_enable = 0; mem_rdata = 0;
    @(posedge clk); #1;
    do_reset();
    check("reset_arb_timeout", 32'(cap_to), 32'd0);

    // Lone instruction fetch, memory answers on the third granted cycle.
    mem_mode = 2; i_read = 1; i_address = 16'h0010;
    step();
    check("fetch_idle_read", 32'(cap_mem_read), 32'd0);
    step();
    check("fetch_read", 32'(cap_mem_read), 32'd1);
    check("fetch_addr", 32'(cap_addr), 32'h0010);
    step();
    check("fetch_early_resp", 32'(cap_i_resp), 32'd0);
    mem_resp = 1; step(); mem_resp = 0;
    check("fetch_resp", 32'(cap_i_resp), 32'd1);
    agents(); step();

    // Lone data read leaves last grant on DATA, then two contention rounds.
    mem_mode = 1;
    d_read = 1; d_address = 16'h1234; d_byte_enable = 2'b11;
    resp_log.delete();
    run_until(1);
    for (int r = 0; r < 2; r++) begin
      resp_log.delete();
      i_read = 1; i_address = 16'h0100 + 16'(r);
      d_read = 1; d_address = 16'h2200 + 16'(r);
      run_until(2);
`ifdef ARB_ROUND_ROBIN_EN
      check("contend_first", 32'(resp_log[0]), 32'd0);
      check("contend_second", 32'(resp_log[1]), 32'd1);
`else
      check("contend_first", 32'(resp_log[0]), 32'd1);
      check("contend_second", 32'(resp_log[1]), 32'd0);
`endif
    end

    // Write with a simultaneous read: the write wins.
    mem_mode = 2; mem_resp = 0;
    d_read = 1; d_write = 1; d_byte_enable = 2'b01;
    d_address = 16'h2000; d_wdata = 16'hBEEF;
    step(); step();
    check("wr_write", 32'(cap_mem_write), 32'd1);
    check("wr_read",  32'(cap_mem_read),  32'd0);
    check("wr_be",    32'(cap_be),        32'd1);
    check("wr_addr",  32'(cap_addr),      32'h2000);
    check("wr_wdata", 32'(cap_wdata),     32'hBEEF);
    mem_resp = 1; step(); mem_resp = 0;
    check("wr_resp", 32'(cap_d_resp), 32'd1);
    agents();

    // Hung memory: timeout after the limit, grant kept, reset clears.
    do_reset();
    mem_mode = 0; i_read = 1; i_address = 16'h0044;
    step();
    for (int k = 0; k < c_timeout; k++) step();
    check("wd_before", 32'(cap_to), 32'd0);
    step(); step();
    check("wd_set",  32'(cap_to),       32'd1);
    check("wd_held", 32'(cap_mem_read), 32'd1);
    do_reset();
    step();
    check("wd_cleared", 32'(cap_to), 32'd0);

    // Reset during a data grant with a fetch waiting behind it.
    mem_mode = 2; mem_resp = 0;
    i_read = 1; i_address = 16'h0040;
    d_read = 1; d_address = 16'h3000; d_byte_enable = 2'b11;
    step(); step();
    check("rst_mid_addr", 32'(cap_addr), 32'h3000);
    reset = 1; d_read = 0; step(); reset = 0;
    step();
    check("rst_idle_read",  32'(cap_mem_read),  32'd0);
    check("rst_idle_write", 32'(cap_mem_write), 32'd0);
    check("rst_no_dresp",   32'(cap_d_resp),    32'd0);
    step();
    check("rst_fetch_read", 32'(cap_mem_read), 32'd1);
    check("rst_fetch_addr", 32'(cap_addr),     32'h0040);
    mem_resp = 1; step(); mem_resp = 0;
    agents();

    // Randomized traffic with occasional resets.
    mem_mode = 1; agent_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      step(); agents();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
